// File: rtl/nios_system_keycode_in.sv
// Avalon-MM input PIO: synchronised in_port, sticky edge capture, level irq.
// Optional IRQMASK register and irq output enabled by KEYCODE_IN_IRQ_EN.
module nios_system_keycode_in #(
    parameter int DATA_WIDTH = 8,
    parameter int EDGE_TYPE  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    localparam int W = DATA_WIDTH;

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;
    logic [W-1:0] prev;
    logic [W-1:0] edgecap;
    logic [W-1:0] det_raw;
    logic [W-1:0] det;
    logic [W-1:0] clr;
    logic [W-1:0] mask_rd;
    logic [1:0]   warm;
    logic         wr;
    logic [31:0]  rd_next;
    logic         unused_ok;

    assign wr        = chipselect & ~write_n;
    assign unused_ok = ^writedata;

    always_comb begin
        det_raw = '0;
        if (EDGE_TYPE == 1)
            det_raw = ~sync2 & prev;
        else if (EDGE_TYPE == 2)
            det_raw = sync2 ^ prev;
        else
            det_raw = sync2 & ~prev;
    end

    // Mask detection until the synchroniser holds real samples
    assign det = (warm == 2'd3) ? det_raw : '0;
    assign clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;

`ifdef KEYCODE_IN_IRQ_EN
    logic [W-1:0] irqmask;

    always_ff @(posedge clk) begin
        if (reset)
            irqmask <= '0;
        else if (wr && address == 2'd2)
            irqmask <= writedata[W-1:0];
    end

    assign mask_rd = irqmask;
    assign irq     = |(edgecap & irqmask);
`else
    assign mask_rd = '0;
    assign irq     = 1'b0;
`endif

    always_comb begin
        rd_next = '0;
        unique case (address)
            2'd0: rd_next[W-1:0] = sync2;
            2'd1: rd_next        = '0;
            2'd2: rd_next[W-1:0] = mask_rd;
            2'd3: rd_next[W-1:0] = edgecap;
            default: rd_next     = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            prev     <= '0;
            edgecap  <= '0;
            warm     <= 2'd0;
            readdata <= '0;
        end else begin
            sync1    <= in_port;
            sync2    <= sync1;
            prev     <= sync2;
            if (warm != 2'd3)
                warm <= warm + 2'd1;
            // A new edge wins over a same-cycle clear
            edgecap  <= (edgecap & ~clr) | det;
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_nios_system_keycode_in.sv
// Bench for nios_system_keycode_in: rising and any-edge instances
// checked against a sample-history reference model.
module tb_nios_system_keycode_in;

`ifdef KEYCODE_IN_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] rd_r, rd_a;
    logic        irq_r, irq_a;

    int total = 0;
    int bad = 0;

    // Model: smp[k] = in_port sampled k+1 edges ago
    logic [7:0] smp [3];
    int         since_rel;
    logic [7:0] m_ec_r, m_ec_a, m_mask;
    logic [31:0] m_rd_r, m_rd_a;

    always #5 clk = ~clk;

    nios_system_keycode_in #(.DATA_WIDTH(8), .EDGE_TYPE(0)) dut_r (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd_r), .irq(irq_r)
    );

    nios_system_keycode_in #(.DATA_WIDTH(8), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .in_port(in_port),
        .readdata(rd_a), .irq(irq_a)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_of(input logic [1:0] a,
                                          input logic [7:0] ec);
        logic [31:0] r;
        r = '0;
        if (a == 2'd0) r[7:0] = smp[1];
        if (a == 2'd2 && IRQ_EN) r[7:0] = m_mask;
        if (a == 2'd3) r[7:0] = ec;
        return r;
    endfunction

    task automatic step(input logic [1:0] a, input logic wr_en,
                        input logic [7:0] wd);
        logic [7:0] s2, pv, clr;
        address = a;
        if (wr_en) begin
            chipselect = 1'b1;
            write_n    = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
            chipselect = 1'b0;
            write_n    = 1'($urandom_range(0, 1));
        end else begin
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'b1;
        end
        writedata = {24'($urandom), wd};
        @(posedge clk);
        if (reset) begin
            smp       = '{8'h00, 8'h00, 8'h00};
            since_rel = 0;
            m_ec_r    = '0;
            m_ec_a    = '0;
            m_mask    = '0;
            m_rd_r    = '0;
            m_rd_a    = '0;
        end else begin
            s2     = smp[1];
            pv     = smp[2];
            m_rd_r = rd_of(a, m_ec_r);
            m_rd_a = rd_of(a, m_ec_a);
            clr    = (wr_en && a == 2'd3) ? wd : 8'h00;
            m_ec_r = m_ec_r & ~clr;
            m_ec_a = m_ec_a & ~clr;
            if (since_rel >= 3) begin
                m_ec_r = m_ec_r | (s2 & ~pv);
                m_ec_a = m_ec_a | (s2 ^ pv);
            end
            if (IRQ_EN && wr_en && a == 2'd2) m_mask = wd;
            smp[2] = smp[1];
            smp[1] = smp[0];
            smp[0] = in_port;
            if (since_rel < 100) since_rel++;
        end
        #1;
        chk("rd_rise", rd_r, m_rd_r);
        chk("rd_any", rd_a, m_rd_a);
        chk("irq_rise", {31'd0, irq_r},
            {31'd0, IRQ_EN && |(m_ec_r & m_mask)});
        chk("irq_any", {31'd0, irq_a},
            {31'd0, IRQ_EN && |(m_ec_a & m_mask)});
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) step(a, 1'b0, 8'h00);
    endtask

    initial begin
        reset      = 1'b1;
        in_port    = 8'hA5;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        smp        = '{8'h00, 8'h00, 8'h00};
        since_rel  = 0;
        m_ec_r     = '0;
        m_ec_a     = '0;
        m_mask     = '0;

        // Reset then DATA read
        idle(2, 2'd0);
        chk("reset_rd", rd_r, 32'h0);
        chk("reset_irq", {31'd0, irq_r}, 32'h0);
        reset = 1'b0;
        idle(2, 2'd0);
        chk("data_early", rd_r, 32'h0);
        idle(1, 2'd0);
        chk("data_a5", rd_r, 32'hA5);
        idle(3, 2'd3);
        chk("warm_ec_r", rd_r, 32'h0);
        chk("warm_ec_a", rd_a, 32'h0);

        // Rising capture and irq
        step(2'd2, 1'b1, 8'h01);
        in_port = 8'hA4;
        idle(4, 2'd3);
        step(2'd3, 1'b1, 8'hFF);
        in_port = 8'hA5;
        idle(3, 2'd3);
        chk("rise_irq", {31'd0, irq_r}, {31'd0, IRQ_EN});
        idle(1, 2'd3);
        chk("rise_ec", rd_r, 32'h01);
        in_port = 8'hA4;
        idle(5, 2'd3);
        chk("fall_keeps", rd_r, 32'h01);

        // Write-1-to-clear
        in_port = 8'h00;
        idle(4, 2'd3);
        step(2'd3, 1'b1, 8'hFF);
        in_port = 8'h03;
        idle(5, 2'd3);
        chk("w1c_pre", rd_r, 32'h03);
        step(2'd3, 1'b1, 8'h01);
        chk("w1c_irq", {31'd0, irq_r}, 32'h0);
        idle(1, 2'd3);
        chk("w1c_ec", rd_r, 32'h02);

        // Simultaneous set and clear on bit 0
        in_port = 8'h02;
        idle(4, 2'd3);
        step(2'd3, 1'b1, 8'hFF);
        in_port = 8'h03;
        idle(2, 2'd3);
        step(2'd3, 1'b1, 8'h01);
        chk("simul_irq", {31'd0, irq_r}, {31'd0, IRQ_EN});
        idle(1, 2'd3);
        chk("simul_ec", rd_r, 32'h01);

        // Any-edge toggles on bit 3
        in_port = 8'h00;
        idle(4, 2'd3);
        step(2'd3, 1'b1, 8'hFF);
        in_port = 8'h08;
        idle(4, 2'd3);
        idle(1, 2'd3);
        chk("any_up", rd_a, 32'h08);
        step(2'd3, 1'b1, 8'hFF);
        in_port = 8'h00;
        idle(4, 2'd3);
        idle(1, 2'd3);
        chk("any_down", rd_a, 32'h08);
        chk("rise_no_fall", rd_r, 32'h00);

        // Mask register visibility
        step(2'd3, 1'b1, 8'hFF);
        step(2'd2, 1'b1, 8'hFF);
        idle(1, 2'd2);
        chk("mask_rd", rd_r, IRQ_EN ? 32'hFF : 32'h0);
        in_port = 8'h01;
        idle(4, 2'd3);
        chk("mask_irq", {31'd0, irq_r}, {31'd0, IRQ_EN});
        idle(1, 2'd3);
        chk("mask_ec", rd_r, 32'h01);

        // Randomised traffic with one mid-run reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
            reset = (i == 200);
            step(2'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
